branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined RV32I core. It replaces the fixed "fetch PC+4 until execute resolves" policy. It supplies a predicted next PC to the fetch stage from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It trains the tables from the execute stage and raises redirect/flush signals on a mispredict. It sits beside the fetch stage; its fetch-side outputs drive the PC mux, and its execute-side outputs drive the fetch/decode and decode/execute register flushes.

## Interface
- WIDTH, 32, address/data width in bits
- ENTRIES, 16, BTB/counter table depth; power of two, >= 2; IDX = log2(ENTRIES)
- CNT_WIDTH, 32, width of the performance counters
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- PC_F  input  WIDTH  current fetch PC
- predTaken_F  output  1  fetch-stage prediction: taken
- nextPC_F  output  WIDTH  predicted next fetch PC
- update_E  input  1  execute stage holds a valid branch or jump this cycle
- jump_E  input  1  execute-stage instruction is JAL/JALR (always taken)
- taken_E  input  1  resolved branch outcome (ignored when jump_E=1)
- PC_E  input  WIDTH  PC of the execute-stage instruction
- PCPlus4_E  input  WIDTH  PC_E+4
- PCTarget_E  input  WIDTH  resolved target address
- predTaken_E  input  1  prediction made for this instruction, piped F->E
- predTarget_E  input  WIDTH  nextPC_F made for this instruction, piped F->E
- mispredict_E  output  1  redirect required this cycle
- redirectPC_E  output  WIDTH  correct next PC when mispredict_E=1
- flush_D  output  1  clear fetch/decode register
- flush_E  output  1  clear decode/execute register
- branchCount  output  CNT_WIDTH  resolved branches/jumps since reset
- mispredCount  output  CNT_WIDTH  mispredicts since reset

## Operation
- Index = PC[IDX+1:2]; tag = PC[WIDTH-1:IDX+2]; PC[1:0] ignored.
- Each entry holds valid (1b), tag, target (WIDTH), ctr (2b: 00 SNT, 01 WNT, 10 WT, 11 ST).
- Prediction (combinational from PC_F): hit = valid && tag match; predTaken_F = hit && ctr[1]; nextPC_F = predTaken_F ? target : PC_F+4 (mod 2^WIDTH).
- Actual taken A = jump_E | taken_E. Actual next PC N = A ? PCTarget_E : PCPlus4_E.
- mispredict_E = update_E && (predTaken_E != A || (A && predTarget_E != PCTarget_E)); redirectPC_E = N.
- flush_D = flush_E = mispredict_E. When update_E=0, mispredict_E=0 and redirectPC_E = PCPlus4_E.
- Training on update_E, using the entry indexed by PC_E:
  - A=1 and hit: ctr saturating +1 (jump_E: ctr := 11); target := PCTarget_E.
  - A=1 and miss: valid := 1, tag := PC_E tag, target := PCTarget_E, ctr := 10 (jump_E: 11); the previous occupant is overwritten.
  - A=0 and hit: ctr saturating -1; target unchanged.
  - A=0 and miss: no change (no allocation on not-taken).
- Counters: branchCount +1 on each update_E; mispredCount +1 on each mispredict_E. Both saturate at all-ones and never wrap.

## Timing
- Reset (rst=1 at edge): all valid := 0, all ctr := 01, branchCount := 0, mispredCount := 0. Targets and tags are don't-care.
- Outputs after reset: predTaken_F=0, nextPC_F=PC_F+4, mispredict_E=0, flush_D=flush_E=0.
- rst wins over a simultaneous update_E; no training occurs in that cycle.
- Prediction latency is 0 cycles (combinational table read). Training is visible to fetch from the cycle after the update edge.
- No bypass: when PC_F and PC_E map to the same index in one cycle, fetch sees the pre-update entry.
- mispredict_E is combinational in the execute cycle. The fetch PC register loads redirectPC_E at the same edge at which the pipeline flushes are taken.
- Mispredict penalty is 2 cycles (the D and E bubbles); a correct prediction costs 0 cycles.
- Counter saturation: 00 -1 stays 00; 11 +1 stays 11.
- Tables are single-write-port; there is at most one update per cycle.

## Test plan
- Reset, then PC_F=0x100 -> predTaken_F=0, nextPC_F=0x104; both counters 0.
- Cold branch at 0x100 taken to 0x80 (predTaken_E=0) -> mispredict_E=1, redirectPC_E=0x80, flush_D=flush_E=1. Next cycle PC_F=0x100 -> predTaken_F=1, nextPC_F=0x80.
- Same branch taken 3 more times, then not taken -> ctr 10->11->11->11, then 10. Still predicted taken; the not-taken resolution gives mispredict_E=1 with redirectPC_E=0x104; mispredCount=2.
- Aliasing with ENTRIES=16: branch at 0x100 then 0x140 (same index, different tag), both taken -> 0x140 overwrites the entry; PC_F=0x100 now misses and predicts 0x104.
- JALR at 0x200 predicted taken to 0x300 but resolves to 0x340 -> mispredict_E=1, redirectPC_E=0x340; target updated; ctr=11.
- rst asserted in the same cycle as update_E with mispredict -> counters 0 and valid 0 after the edge; no allocation.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle between the pipeline and the branch predictor.
// The pipeline side is the master; the predictor side is the slave.
interface branch_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] PC_F;
    logic             predTaken_F;
    logic [WIDTH-1:0] nextPC_F;

    logic             update_E;
    logic             jump_E;
    logic             taken_E;
    logic [WIDTH-1:0] PC_E;
    logic [WIDTH-1:0] PCPlus4_E;
    logic [WIDTH-1:0] PCTarget_E;
    logic             predTaken_E;
    logic [WIDTH-1:0] predTarget_E;
    logic             mispredict_E;
    logic [WIDTH-1:0] redirectPC_E;
    logic             flush_D;
    logic             flush_E;

    modport master (
        output PC_F, update_E, jump_E, taken_E, PC_E, PCPlus4_E, PCTarget_E,
               predTaken_E, predTarget_E,
        input  predTaken_F, nextPC_F, mispredict_E, redirectPC_E, flush_D, flush_E
    );

    modport slave (
        input  PC_F, update_E, jump_E, taken_E, PC_E, PCPlus4_E, PCTarget_E,
               predTaken_E, predTarget_E,
        output predTaken_F, nextPC_F, mispredict_E, redirectPC_E, flush_D, flush_E
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch-side
// prediction, execute-side training, mispredict redirect and perf counters.
module branch_predictor #(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_if.slave    bp,
    output logic [CNT_WIDTH-1:0] branchCount,
    output logic [CNT_WIDTH-1:0] mispredCount
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - IDX - 2;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
    logic [ENTRIES-1:0][TAGW-1:0]  tag_q;
    logic [ENTRIES-1:0][WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0]          branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]          mispred_cnt_q, mispred_cnt_d;

    logic [IDX-1:0]  idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, hit_e;
    logic            act_taken;
    logic            mispredict;
    logic            wr_en;
    logic [1:0]      unused_pc_e_lo;

    assign idx_f = bp.PC_F[IDX+1:2];
    assign tag_f = bp.PC_F[WIDTH-1:IDX+2];
    assign idx_e = bp.PC_E[IDX+1:2];
    assign tag_e = bp.PC_E[WIDTH-1:IDX+2];
    assign unused_pc_e_lo = bp.PC_E[1:0];

    // Fetch reads the registered table only, so a same-cycle update is not bypassed.
    assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign bp.predTaken_F = hit_f && ctr_q[idx_f][1];
    assign bp.nextPC_F    = bp.predTaken_F ? target_q[idx_f] : bp.PC_F + WIDTH'(4);

    assign hit_e      = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign act_taken  = bp.jump_E | bp.taken_E;
    assign mispredict = bp.update_E &&
                        ((bp.predTaken_E != act_taken) ||
                         (act_taken && (bp.predTarget_E != bp.PCTarget_E)));

    assign bp.mispredict_E = mispredict;
    assign bp.redirectPC_E = (bp.update_E && act_taken) ? bp.PCTarget_E : bp.PCPlus4_E;
    assign bp.flush_D      = mispredict;
    assign bp.flush_E      = mispredict;

    assign branchCount  = branch_cnt_q;
    assign mispredCount = mispred_cnt_q;

    always_comb begin
        valid_d       = valid_q;
        ctr_d         = ctr_q;
        wr_en         = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.update_E) begin
            if (act_taken) begin
                // Taken resolutions allocate on a miss, evicting whatever aliased there.
                wr_en          = 1'b1;
                valid_d[idx_e] = 1'b1;
                if (bp.jump_E)
                    ctr_d[idx_e] = 2'b11;
                else if (!hit_e)
                    ctr_d[idx_e] = 2'b10;
                else if (ctr_q[idx_e] != 2'b11)
                    ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
            end else if (hit_e && ctr_q[idx_e] != 2'b00) begin
                ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
            end
            if (branch_cnt_q != '1)
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispredict && mispred_cnt_q != '1)
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            ctr_q         <= {ENTRIES{2'b01}};
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= bp.PCTarget_E;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of hand-computed rows plus
// a reset-collides-with-update sequence; a 2-bit-counter instance checks saturation.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] bc, mc;
    logic [1:0]  bc2, mc2;

    always #5 clk = ~clk;

    branch_predictor_if #(.WIDTH(32)) bp ();
    branch_predictor_if #(.WIDTH(32)) bp2 ();

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bp(bp), .branchCount(bc), .mispredCount(mc)
    );

    branch_predictor #(.WIDTH(32), .ENTRIES(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .bp(bp2), .branchCount(bc2), .mispredCount(mc2)
    );

    assign bp2.PC_F         = bp.PC_F;
    assign bp2.update_E     = bp.update_E;
    assign bp2.jump_E       = bp.jump_E;
    assign bp2.taken_E      = bp.taken_E;
    assign bp2.PC_E         = bp.PC_E;
    assign bp2.PCPlus4_E    = bp.PCPlus4_E;
    assign bp2.PCTarget_E   = bp.PCTarget_E;
    assign bp2.predTaken_E  = bp.predTaken_E;
    assign bp2.predTarget_E = bp.predTarget_E;

    typedef struct {
        logic [31:0] pc_f;
        logic        upd, jmp, tkn;
        logic [31:0] pc_e, tgt;
        logic        pt_e;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_npc;
        logic        e_mp;
        logic [31:0] e_rd;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic [31:0] pc_f, input logic upd, jmp, tkn,
                       input logic [31:0] pc_e, tgt, input logic pt_e,
                       input logic [31:0] ptgt, input logic e_pt,
                       input logic [31:0] e_npc, input logic e_mp,
                       input logic [31:0] e_rd, input int e_bc, e_mc);
        vec_t v;
        v.pc_f = pc_f; v.upd = upd; v.jmp = jmp; v.tkn = tkn;
        v.pc_e = pc_e; v.tgt = tgt; v.pt_e = pt_e; v.ptgt = ptgt;
        v.e_pt = e_pt; v.e_npc = e_npc; v.e_mp = e_mp; v.e_rd = e_rd;
        v.e_bc = e_bc; v.e_mc = e_mc;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc_f, input logic upd, jmp, tkn,
                         input logic [31:0] pc_e, tgt, input logic pt_e,
                         input logic [31:0] ptgt);
        bp.PC_F         = pc_f;
        bp.update_E     = upd;
        bp.jump_E       = jmp;
        bp.taken_E      = tkn;
        bp.PC_E         = pc_e;
        bp.PCPlus4_E    = pc_e + 32'd4;
        bp.PCTarget_E   = tgt;
        bp.predTaken_E  = pt_e;
        bp.predTarget_E = ptgt;
    endtask

    initial begin
        //   pc_f  upd jmp tkn pc_e   tgt    pt_e ptgt  | pt npc  mp rd  bc mc
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   0, 0);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  0, 0);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  1, 1);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  2, 1);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  3, 1);
        add(32'h100, 1,0,0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 4, 1);
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,   5, 2);
        add(32'h100, 1,0,0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104, 5, 2);
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   6, 3);
        add(32'h100, 1,0,0, 32'h100, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104, 6, 3);
        add(32'h100, 1,0,0, 32'h100, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104, 7, 3);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  8, 3);
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   9, 4);
        add(32'h100, 1,0,1, 32'h100, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  9, 4);
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h4,   10, 5);
        // aliasing: 0x140 shares index 0 with 0x100
        add(32'h140, 1,0,1, 32'h140, 32'h40,  0, 32'h144, 0, 32'h144, 1, 32'h40,  10, 5);
        add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   11, 6);
        add(32'h140, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h40,  0, 32'h4,   11, 6);
        add(32'h104, 1,0,0, 32'h104, 32'h80,  0, 32'h108, 0, 32'h108, 0, 32'h108, 11, 6);
        add(32'h104, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h108, 0, 32'h4,   12, 6);
        // JALR at 0x200: allocate, then wrong target, then correct
        add(32'h200, 1,1,0, 32'h200, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 12, 6);
        add(32'h200, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,   13, 7);
        add(32'h200, 1,1,0, 32'h200, 32'h340, 1, 32'h300, 1, 32'h300, 1, 32'h340, 13, 7);
        add(32'h200, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h340, 0, 32'h4,   14, 8);
        add(32'h200, 1,1,0, 32'h200, 32'h340, 1, 32'h340, 1, 32'h340, 0, 32'h340, 14, 8);
        add(32'hFFFF_FFFC, 0,0,0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0,   0, 32'h4,   15, 8);

        rst = 1'b1;
        drive(32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            string s;
            @(negedge clk);
            drive(vt[i].pc_f, vt[i].upd, vt[i].jmp, vt[i].tkn,
                  vt[i].pc_e, vt[i].tgt, vt[i].pt_e, vt[i].ptgt);
            #1;
            s = $sformatf("row%0d", i);
            chk({s, " predTaken_F"},  {31'd0, bp.predTaken_F},  {31'd0, vt[i].e_pt});
            chk({s, " nextPC_F"},     bp.nextPC_F,              vt[i].e_npc);
            chk({s, " mispredict_E"}, {31'd0, bp.mispredict_E}, {31'd0, vt[i].e_mp});
            chk({s, " flush_D"},      {31'd0, bp.flush_D},      {31'd0, vt[i].e_mp});
            chk({s, " flush_E"},      {31'd0, bp.flush_E},      {31'd0, vt[i].e_mp});
            chk({s, " redirectPC_E"}, bp.redirectPC_E,          vt[i].e_rd);
            chk({s, " branchCount"},  bc,                       32'(vt[i].e_bc));
            chk({s, " mispredCount"}, mc,                       32'(vt[i].e_mc));
            chk({s, " sat branchCount"},  {30'd0, bc2}, (vt[i].e_bc > 3) ? 32'd3 : 32'(vt[i].e_bc));
            chk({s, " sat mispredCount"}, {30'd0, mc2}, (vt[i].e_mc > 3) ? 32'd3 : 32'(vt[i].e_mc));
        end

        // reset collides with a mispredicting taken update: reset must win
        @(negedge clk);
        rst = 1'b1;
        drive(32'h104, 1, 0, 1, 32'h104, 32'h500, 0, 32'h108);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h104, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        chk("rst+upd predTaken_F", {31'd0, bp.predTaken_F}, 32'd0);
        chk("rst+upd nextPC_F",    bp.nextPC_F,             32'h108);
        chk("rst+upd mispredict",  {31'd0, bp.mispredict_E}, 32'd0);
        chk("rst+upd branchCount", bc, 32'd0);
        chk("rst+upd mispredCount", mc, 32'd0);
        chk("rst+upd sat counts",  {28'd0, bc2, mc2}, 32'd0);
        @(negedge clk);
        bp.PC_F = 32'h200;
        #1;
        chk("rst valid cleared predTaken_F", {31'd0, bp.predTaken_F}, 32'd0);
        chk("rst valid cleared nextPC_F",    bp.nextPC_F,             32'h204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
